fetch_decode: RTL and testbench
===============================

Name: fetch_decode

Overview:
- Instruction fetch and decode stage directly upstream of the register/ALU/data-memory datapath.
- Holds the PC and fetches 32-bit MIPS instructions from instruction memory over a request/valid handshake.
- Decodes each instruction into the register addresses, immediate, ALU control and control flags the datapath consumes.
- Passes decoded instructions downstream with a valid/ready handshake, and accepts PC redirects from branch resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, maximum cycles to wait for imem_valid before halting with an error; 1..255.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  fetch address; always equals pc, low 2 bits 0.
- imem_read  out  1  fetch request; high only in state FETCH.
- imem_data  in  32  instruction word; sampled only when imem_valid=1 in FETCH.
- imem_valid  in  1  instruction memory response strobe.
- redirect  in  1  load redirect_pc as the next fetch address.
- redirect_pc  in  32  branch/jump target; bits [1:0] forced to 0.
- dec_valid  out  1  decoded instruction valid.
- dec_ready  in  1  downstream accepts the decoded instruction.
- rs, rt, rd  out  5 each  source A, source B, and write-destination register addresses.
- immediate  out  16  instr[15:0].
- alu_control  out  2  00 add, 01 sub, 10 and, 11 or.
- use_imm, reg_write, is_load, is_store, is_branch  out  1 each  control flags.
- pc_out  out  32  PC of the instruction currently presented.
- err_illegal  out  1  one-cycle pulse per undecodable instruction.
- err_fetch_timeout  out  1  sticky; cleared only by reset.

Behaviour:
- **Reset (async):**
  - pc=RESET_PC and state=FETCH.
  - All decode outputs 0; dec_valid=0; errors=0; wait counter=0.
  - imem_read rises in the first cycle after reset deasserts.
- **States:** FETCH, DECODE, ISSUE, HALT.
- **FETCH:**
  - imem_read=1 and imem_addr=pc.
  - On imem_valid=1: latch imem_data, clear the wait counter, go to DECODE.
  - Otherwise increment the wait counter. If the counter reaches FETCH_TIMEOUT, set err_fetch_timeout and go to HALT.
  - A response arriving in the same cycle as a timeout is ignored.
- **DECODE (one cycle):** register all output fields from the latched word.
  - R-type (op=000000): funct 100000 add, 100010 sub, 100100 and, 100101 or. Sets rd=instr[15:11], reg_write=1, use_imm=0.
  - addi (001000): add; rd=rt; use_imm=1; reg_write=1.
  - lw (100011): add; rd=rt; use_imm=1; reg_write=1; is_load=1.
  - sw (101011): add; rd=0; use_imm=1; is_store=1.
  - beq (000100): sub; rd=0; is_branch=1.
  - Anything else is illegal:
    - pulse err_illegal for one cycle;
    - do not assert dec_valid;
    - pc<=pc+4;
    - go to FETCH.
  - A legal instruction goes to ISSUE.
- **ISSUE:**
  - dec_valid=1 and all outputs held stable until dec_ready=1.
  - On dec_ready: pc<=pc+4, dec_valid drops the next cycle, go to FETCH.
  - dec_ready is ignored when dec_valid=0.
- **HALT:** imem_read=0 and dec_valid=0; exits only via reset. redirect is ignored.
- **Redirect:**
  - In FETCH, DECODE or ISSUE, redirect=1 has priority over every other transition.
  - It sets pc<={redirect_pc[31:2],2'b00}, clears dec_valid and the wait counter, and sets state=FETCH.
  - Any imem_valid in the same cycle is discarded.
  - Redirect coincident with dec_ready: the handshake completes, but the redirect target wins over pc+4.
- **Arithmetic:** PC increments modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- **Throughput:** minimum 3 cycles per instruction (FETCH, DECODE, ISSUE with zero-wait memory and dec_ready held high).
- **pc_out:** equals pc throughout DECODE and ISSUE.

Test Plan:
- Reset, imem_valid=1 returning 0x012A4020 (add $8,$9,$10), dec_ready=1 → dec_valid in the 3rd cycle with rs=9, rt=10, rd=8, alu_control=00, reg_write=1, pc_out=0; next imem_addr=4.
- Fetch 0x8D280004 (lw $8,4($9)) with dec_ready low for 5 cycles → dec_valid held, outputs stable, is_load=1, use_imm=1, rd=8, immediate=0x0004; pc advances only after dec_ready.
- Fetch 0xFC000000 → err_illegal pulses exactly one cycle, no dec_valid, next imem_addr=pc+4.
- imem_valid held low → after 16 FETCH cycles err_fetch_timeout=1, imem_read=0 permanently; a later redirect has no effect; reset clears.
- In ISSUE, assert redirect=1 with redirect_pc=0x0000_0103 → dec_valid drops, next imem_addr=0x0000_0100.
- Redirect to 0xFFFF_FFFC, legal instruction accepted → next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/fetch_decode.sv
// fetch_decode: MIPS fetch/decode stage. It fetches over a request/valid
// handshake and presents decoded fields downstream with valid/ready.
// Ports: clock/reset; imem_addr/imem_read/imem_data/imem_valid (fetch);
// redirect/redirect_pc (branch resolution); dec_valid/dec_ready (issue);
// rs/rt/rd/immediate/alu_control plus the control flags; pc_out;
// err_illegal (one-cycle pulse); err_fetch_timeout (sticky).
module fetch_decode #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_read,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] immediate,
  output logic [1:0]  alu_control,
  output logic        use_imm,
  output logic        reg_write,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic [31:0] pc_out,
  output logic        err_illegal,
  output logic        err_fetch_timeout
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  // Count of the last allowed waiting cycle; a miss (or even a hit)
  // here is the timeout.
  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [7:0]  wait_cnt;

  logic [31:0] pc_inc;
  logic [31:0] pc_redir;

  logic        d_legal;
  logic [1:0]  d_alu;
  logic [4:0]  d_rd;
  logic        d_imm;
  logic        d_wr;
  logic        d_ld;
  logic        d_st;
  logic        d_br;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        unused_shamt;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  assign pc_inc    = pc + 32'd4;
  assign pc_redir  = {redirect_pc[31:2], 2'b00};
  assign imem_addr = pc;
  assign imem_read = (state == S_FETCH);
  assign pc_out    = pc;

  always_comb begin
    d_legal = 1'b1;
    d_alu   = 2'b00;
    d_rd    = 5'd0;
    d_imm   = 1'b0;
    d_wr    = 1'b0;
    d_ld    = 1'b0;
    d_st    = 1'b0;
    d_br    = 1'b0;
    unique case (1'b1)
      (op == OP_R): begin
        d_rd = instr[15:11];
        d_wr = 1'b1;
        unique case (funct)
          6'b100000: d_alu = 2'b00;
          6'b100010: d_alu = 2'b01;
          6'b100100: d_alu = 2'b10;
          6'b100101: d_alu = 2'b11;
          default:   d_legal = 1'b0;
        endcase
      end
      (op == OP_ADDI): begin
        d_rd  = instr[20:16];
        d_imm = 1'b1;
        d_wr  = 1'b1;
      end
      (op == OP_LW): begin
        d_rd  = instr[20:16];
        d_imm = 1'b1;
        d_wr  = 1'b1;
        d_ld  = 1'b1;
      end
      (op == OP_SW): begin
        d_imm = 1'b1;
        d_st  = 1'b1;
      end
      (op == OP_BEQ): begin
        d_alu = 2'b01;
        d_br  = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_FETCH;
      pc                <= RESET_PC;
      instr             <= 32'd0;
      wait_cnt          <= 8'd0;
      dec_valid         <= 1'b0;
      rs                <= 5'd0;
      rt                <= 5'd0;
      rd                <= 5'd0;
      immediate         <= 16'd0;
      alu_control       <= 2'b00;
      use_imm           <= 1'b0;
      reg_write         <= 1'b0;
      is_load           <= 1'b0;
      is_store          <= 1'b0;
      is_branch         <= 1'b0;
      err_illegal       <= 1'b0;
      err_fetch_timeout <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      // Redirect beats everything except HALT, including a
      // coincident dec_ready (handshake done, target wins).
      if (redirect && state != S_HALT) begin
        pc        <= pc_redir;
        dec_valid <= 1'b0;
        wait_cnt  <= 8'd0;
        state     <= S_FETCH;
      end else begin
        unique case (state)
          S_FETCH: begin
            if (wait_cnt == WAIT_LAST) begin
              err_fetch_timeout <= 1'b1;
              state             <= S_HALT;
            end else if (imem_valid) begin
              instr    <= imem_data;
              wait_cnt <= 8'd0;
              state    <= S_DECODE;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          S_DECODE: begin
            if (d_legal) begin
              rs          <= instr[25:21];
              rt          <= instr[20:16];
              rd          <= d_rd;
              immediate   <= instr[15:0];
              alu_control <= d_alu;
              use_imm     <= d_imm;
              reg_write   <= d_wr;
              is_load     <= d_ld;
              is_store    <= d_st;
              is_branch   <= d_br;
              dec_valid   <= 1'b1;
              state       <= S_ISSUE;
            end else begin
              err_illegal <= 1'b1;
              pc          <= pc_inc;
              state       <= S_FETCH;
            end
          end
          S_ISSUE: begin
            if (dec_ready) begin
              dec_valid <= 1'b0;
              pc        <= pc_inc;
              state     <= S_FETCH;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed test-plan cases plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_fetch_decode;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  rs, rt, rd;
  logic [15:0] immediate;
  logic [1:0]  alu_control;
  logic        use_imm, reg_write, is_load, is_store, is_branch;
  logic [31:0] pc_out;
  logic        err_illegal;
  logic        err_fetch_timeout;

  int checks = 0;
  int errors = 0;

  fetch_decode #(.RESET_PC(32'h0), .FETCH_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr), .imem_read(imem_read),
    .imem_data(imem_data), .imem_valid(imem_valid),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .rs(rs), .rt(rt), .rd(rd), .immediate(immediate),
    .alu_control(alu_control), .use_imm(use_imm),
    .reg_write(reg_write), .is_load(is_load),
    .is_store(is_store), .is_branch(is_branch),
    .pc_out(pc_out), .err_illegal(err_illegal),
    .err_fetch_timeout(err_fetch_timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        legal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [1:0]  alu;
    logic        ui;
    logic        rw;
    logic        ld;
    logic        st;
    logic        br;
  } exp_t;

  // Reference decode: name the instruction, then derive fields from
  // the mnemonic.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t  e;
    string m;
    logic  rtype;
    m = "bad";
    rtype = (w[31:26] == 6'h00);
    if (rtype) begin
      case (w[5:0])
        6'h20: m = "add";
        6'h22: m = "sub";
        6'h24: m = "and";
        6'h25: m = "or";
        default: m = "bad";
      endcase
    end else begin
      case (w[31:26])
        6'h08: m = "addi";
        6'h23: m = "lw";
        6'h2b: m = "sw";
        6'h04: m = "beq";
        default: m = "bad";
      endcase
    end
    e = '0;
    e.legal = (m != "bad");
    e.rs  = w[25:21];
    e.rt  = w[20:16];
    e.imm = w[15:0];
    if (m == "sub" || m == "beq") e.alu = 2'd1;
    else if (m == "and") e.alu = 2'd2;
    else if (m == "or") e.alu = 2'd3;
    else e.alu = 2'd0;
    e.ui = (m == "addi" || m == "lw" || m == "sw");
    e.rw = (rtype && e.legal) || m == "addi" || m == "lw";
    if (rtype) e.rd = w[15:11];
    else if (m == "addi" || m == "lw") e.rd = w[20:16];
    else e.rd = 5'd0;
    e.ld = (m == "lw");
    e.st = (m == "sw");
    e.br = (m == "beq");
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: 0 = waiting for an instruction word, 1 = word in hand,
  // 2 = decoded instruction on offer downstream.
  int          m_stage;
  logic [31:0] m_pc;
  logic [31:0] m_word;
  int          m_fetch_cycles;
  bit          m_halt;
  bit          m_ill;
  exp_t        m_d;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_stage = 0;
      m_pc = 32'h0;
      m_word = 32'h0;
      m_fetch_cycles = 0;
      m_halt = 0;
      m_ill = 0;
    end else begin
      m_d = ref_decode(m_word);
      m_ill = 0;
      if (m_halt) begin
      end else if (redirect) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_stage = 0;
        m_fetch_cycles = 0;
      end else if (m_stage == 0) begin
        m_fetch_cycles++;
        if (m_fetch_cycles == TIMEOUT) begin
          m_halt = 1;
        end else if (imem_valid) begin
          m_word = imem_data;
          m_stage = 1;
          m_fetch_cycles = 0;
        end
      end else if (m_stage == 1) begin
        if (m_d.legal) begin
          m_stage = 2;
        end else begin
          m_ill = 1;
          m_pc = m_pc + 32'd4;
          m_stage = 0;
        end
      end else if (dec_ready) begin
        m_pc = m_pc + 32'd4;
        m_stage = 0;
      end
    end
  end

  exp_t c_d;
  always @(negedge clock) begin
    if (!reset) begin
      chk("imem_read", imem_read, !m_halt && m_stage == 0);
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_out", pc_out, m_pc);
      chk("dec_valid", dec_valid, m_stage == 2);
      chk("err_illegal", err_illegal, m_ill);
      chk("err_fetch_timeout", err_fetch_timeout, m_halt);
      if (m_stage == 2) begin
        c_d = ref_decode(m_word);
        chk("fields",
            {rs, rt, rd, immediate, alu_control,
             use_imm, reg_write, is_load, is_store, is_branch},
            {c_d.rs, c_d.rt, c_d.rd, c_d.imm, c_d.alu,
             c_d.ui, c_d.rw, c_d.ld, c_d.st, c_d.br});
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  f;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: begin
        case ($urandom_range(0, 3))
          0: f = 6'h20;
          1: f = 6'h22;
          2: f = 6'h24;
          default: f = 6'h25;
        endcase
        w = {6'h00, w[25:6], f};
      end
      1: w = {6'h08, w[25:0]};
      2: w = {6'h23, w[25:0]};
      3: w = {6'h2b, w[25:0]};
      4: w = {6'h04, w[25:0]};
      5: w = {6'h00, w[25:0]};
      default: w = w;
    endcase
    return w;
  endfunction

  exp_t pin;
  int   n;
  logic [37:0] held;

  initial begin
    reset = 1'b1;
    imem_data = 32'h0;
    imem_valid = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    dec_ready = 1'b0;

    pin = ref_decode(32'h012A4020);
    chk("pin_add", {pin.legal, pin.rs, pin.rt, pin.rd, pin.alu, pin.rw},
        {1'b1, 5'd9, 5'd10, 5'd8, 2'd0, 1'b1});
    pin = ref_decode(32'h8D280004);
    chk("pin_lw", {pin.ld, pin.ui, pin.rd, pin.imm},
        {1'b1, 1'b1, 5'd8, 16'h0004});
    pin = ref_decode(32'hFC000000);
    chk("pin_illegal", pin.legal, 1'b0);

    repeat (3) cyc();
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_imem_read", imem_read, 1);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_fields",
        {rs, rt, rd, immediate, alu_control, use_imm, reg_write,
         is_load, is_store, is_branch, err_illegal,
         err_fetch_timeout}, 0);
    reset = 1'b0;

    // add $8,$9,$10
    imem_valid = 1'b1;
    imem_data = 32'h012A4020;
    dec_ready = 1'b1;
    cyc();
    imem_valid = 1'b0;
    chk("add_c2_valid", dec_valid, 0);
    cyc();
    chk("add_valid", dec_valid, 1);
    chk("add_regs", {rs, rt, rd}, {5'd9, 5'd10, 5'd8});
    chk("add_ctl", {alu_control, reg_write, use_imm}, {2'd0, 1'b1, 1'b0});
    chk("add_pc", pc_out, 32'h0);
    cyc();
    dec_ready = 1'b0;
    chk("add_next_addr", imem_addr, 32'h4);
    chk("add_drop", dec_valid, 0);

    // lw $8,4($9) with stall
    imem_valid = 1'b1;
    imem_data = 32'h8D280004;
    cyc();
    imem_valid = 1'b0;
    cyc();
    chk("lw_flags", {is_load, use_imm, rd, immediate},
        {1'b1, 1'b1, 5'd8, 16'h0004});
    held = {rs, rt, rd, immediate, alu_control,
            use_imm, reg_write, is_load, is_store, is_branch};
    for (int i = 0; i < 5; i++) begin
      chk("lw_stall_valid", dec_valid, 1);
      chk("lw_stall_pc", pc_out, 32'h4);
      chk("lw_stall_hold",
          {rs, rt, rd, immediate, alu_control,
           use_imm, reg_write, is_load, is_store, is_branch}, held);
      cyc();
    end
    dec_ready = 1'b1;
    cyc();
    dec_ready = 1'b0;
    chk("lw_next_addr", imem_addr, 32'h8);

    // illegal word
    imem_valid = 1'b1;
    imem_data = 32'hFC000000;
    cyc();
    imem_valid = 1'b0;
    chk("ill_pre", err_illegal, 0);
    cyc();
    chk("ill_pulse", err_illegal, 1);
    chk("ill_no_valid", dec_valid, 0);
    chk("ill_next_addr", imem_addr, 32'hC);
    cyc();
    chk("ill_one_cycle", err_illegal, 0);

    // redirect while issuing addi $9,$8,5
    imem_valid = 1'b1;
    imem_data = 32'h21090005;
    cyc();
    imem_valid = 1'b0;
    cyc();
    chk("addi_valid", {dec_valid, use_imm, rd}, {1'b1, 1'b1, 5'd9});
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    cyc();
    redirect = 1'b0;
    chk("redir_drop", dec_valid, 0);
    chk("redir_addr", imem_addr, 32'h0000_0100);

    // redirect to top of memory, response discarded, then wrap
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    imem_valid = 1'b1;
    imem_data = 32'h012A4020;
    cyc();
    redirect = 1'b0;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    chk("top_discard", imem_read, 1);
    imem_data = 32'h11090003;
    cyc();
    imem_valid = 1'b0;
    cyc();
    chk("beq_ctl", {dec_valid, is_branch, alu_control, rd},
        {1'b1, 1'b1, 2'd1, 5'd0});
    chk("beq_pc", pc_out, 32'hFFFF_FFFC);
    dec_ready = 1'b1;
    cyc();
    dec_ready = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      imem_valid = ($urandom_range(0, 9) < 7);
      imem_data = rand_instr();
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      dec_ready = $urandom_range(0, 1);
      cyc();
    end

    // fetch timeout
    imem_valid = 1'b0;
    redirect = 1'b0;
    dec_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n = 0;
    while (imem_read && n < 40) begin
      n++;
      cyc();
    end
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_err", err_fetch_timeout, 1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    imem_valid = 1'b1;
    repeat (3) cyc();
    redirect = 1'b0;
    imem_valid = 1'b0;
    chk("halt_read", imem_read, 0);
    chk("halt_addr", imem_addr, 32'h0);
    chk("halt_sticky", err_fetch_timeout, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_clear_err", err_fetch_timeout, 0);
    chk("rst_read", imem_read, 1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
